// File: rtl/spi_cs_pkg.sv
// Shared constants and state encoding for the SPI chip-select controller
// and its watchdog.
package spi_cs_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_ASSERT   = 2'd1;
    localparam logic [1:0] ADDR_DEASSERT = 2'd2;
    localparam logic [1:0] ADDR_CTRL     = 2'd3;

    localparam int BUSY_BIT = 31;
    localparam int TMO_BIT  = 30;

    typedef enum logic {
        IDLE = 1'b0,
        GAP  = 1'b1
    } cs_state_t;

endpackage

// File: rtl/spi_cs_wdog.sv
// Hold-time watchdog: counts while run is high, fires once the count reaches
// timeout, and records each firing in a sticky flag.
module spi_cs_wdog
    import spi_cs_pkg::*;
#(
    parameter int TMR_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             run,
    input  logic             restart,
    input  logic [TMR_W-1:0] timeout,
    input  logic             flag_clr,
    output logic             expire,
    output logic             flag
);

    logic [TMR_W-1:0] count_reg;
    logic [TMR_W-1:0] count_next;
    logic [TMR_W-1:0] count_inc;
    logic             flag_reg;
    logic             flag_next;
    logic             active;

    // Comparing the incremented count makes the guarded condition last exactly
    // timeout cycles; a restart in the same cycle suppresses the expiry.
    assign count_inc = count_reg + TMR_W'(1);
    assign active    = run && (timeout != '0);
    assign expire    = active && !restart && (count_inc == timeout);

    always_comb begin
        count_next = count_inc;
        if (!active || restart || expire) begin
            count_next = '0;
        end
    end

    // A set in the same cycle as a clear wins.
    always_comb begin
        flag_next = flag_reg;
        if (expire) begin
            flag_next = 1'b1;
        end else if (flag_clr) begin
            flag_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_reg <= '0;
            flag_reg  <= 1'b0;
        end else begin
            count_reg <= count_next;
            flag_reg  <= flag_next;
        end
    end

    assign flag = flag_reg;

endmodule

// File: rtl/spi_cs_ctrl.sv
// Avalon-MM chip-select controller: N_CS active-low selects with a
// break-before-make guard gap and an optional hold-time watchdog.
module spi_cs_ctrl
    import spi_cs_pkg::*;
#(
    parameter int N_CS       = 2,
    parameter int GAP_CYCLES = 4,
    parameter int TMR_W      = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [1:0]      address,
    input  logic            chipselect,
    input  logic            write_n,
    input  logic [31:0]     writedata,
    output logic [31:0]     readdata,
    output logic [N_CS-1:0] out_port,
    output logic            busy
);

    localparam logic [N_CS-1:0] ALL_OFF = '1;
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    cs_state_t        state_reg, state_next;
    logic [GAP_W-1:0] gap_cnt_reg, gap_cnt_next;
    logic [N_CS-1:0]  target_reg, target_next;
    logic [N_CS-1:0]  cs_out_reg, cs_out_next;
    logic [TMR_W-1:0] timeout_reg, timeout_next;

    logic wr;
    logic data_wr;
    logic ctrl_wr;
    logic new_assert;
    logic gap_enter;
    logic wd_run;
    logic wd_restart;
    logic expire;
    logic tmo_flag;
    logic unused_wdata;

    assign wr      = chipselect && !write_n;
    assign data_wr = wr && (address != ADDR_CTRL);
    assign ctrl_wr = wr && (address == ADDR_CTRL);

    // Per-select target update; a bus write always takes precedence over expiry.
    genvar gi;
    generate
        for (gi = 0; gi < N_CS; gi++) begin : g_target
            assign target_next[gi] =
                (wr && address == ADDR_DATA)                       ? writedata[gi] :
                (wr && address == ADDR_ASSERT   && writedata[gi])  ? 1'b0 :
                (wr && address == ADDR_DEASSERT && writedata[gi])  ? 1'b1 :
                expire                                             ? 1'b1 :
                                                                     target_reg[gi];
        end
    endgenerate

    assign timeout_next = ctrl_wr ? writedata[TMR_W-1:0] : timeout_reg;
    assign unused_wdata = ^writedata;

    assign new_assert = |(cs_out_reg & ~target_reg);
    assign gap_enter  = (state_reg == IDLE) && new_assert && (GAP_CYCLES > 0);

    always_comb begin
        state_next   = state_reg;
        gap_cnt_next = gap_cnt_reg;
        cs_out_next  = cs_out_reg;
        case (state_reg)
            IDLE: begin
                if (expire) begin
                    cs_out_next = ALL_OFF;
                end else if (gap_enter) begin
                    cs_out_next  = ALL_OFF;
                    gap_cnt_next = GAP_LOAD;
                    state_next   = GAP;
                end else begin
                    cs_out_next = target_reg;
                end
            end
            GAP: begin
                // Every select is held off, including ones that were already low.
                cs_out_next = ALL_OFF;
                if (gap_cnt_reg == '0) begin
                    cs_out_next = target_reg;
                    state_next  = IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg - GAP_W'(1);
                end
            end
            default: begin
                state_next  = IDLE;
                cs_out_next = ALL_OFF;
            end
        endcase
    end

    assign wd_run     = (state_reg == IDLE) && (cs_out_reg != ALL_OFF);
    assign wd_restart = data_wr || gap_enter;

    spi_cs_wdog #(
        .TMR_W (TMR_W)
    ) u_wdog (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (wd_run),
        .restart  (wd_restart),
        .timeout  (timeout_reg),
        .flag_clr (ctrl_wr && writedata[TMO_BIT]),
        .expire   (expire),
        .flag     (tmo_flag)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            gap_cnt_reg <= '0;
            target_reg  <= ALL_OFF;
            cs_out_reg  <= ALL_OFF;
            timeout_reg <= '0;
        end else begin
            state_reg   <= state_next;
            gap_cnt_reg <= gap_cnt_next;
            target_reg  <= target_next;
            cs_out_reg  <= cs_out_next;
            timeout_reg <= timeout_next;
        end
    end

    assign out_port = cs_out_reg;
    assign busy     = (state_reg == GAP);

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:                  readdata[N_CS-1:0] = cs_out_reg;
            ADDR_ASSERT, ADDR_DEASSERT: readdata[N_CS-1:0] = target_reg;
            default: begin
                readdata[TMR_W-1:0] = timeout_reg;
                readdata[TMO_BIT]   = tmo_flag;
                readdata[BUSY_BIT]  = busy;
            end
        endcase
    end

endmodule

// File: tb/tb_spi_cs_ctrl.sv
// Directed bench for spi_cs_ctrl with N_CS=2, GAP_CYCLES=4, TMR_W=16.
module tb_spi_cs_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [1:0]  out_port;
    logic        busy;

    int pass_cnt  = 0;
    int total_cnt = 0;

    spi_cs_ctrl #(
        .N_CS       (2),
        .GAP_CYCLES (4),
        .TMR_W      (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single-cycle write; returns 1 time unit after the capturing edge.
    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        $display("wr addr=%0d data=%h out_port=%b", a, d, out_port);
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
        $display("rd addr=%0d data=%h", a, d);
    endtask

    task automatic wait_out(input logic [1:0] val, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (out_port === val) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        total_cnt++;
        if (out_port !== 2'b11) $display("FAIL reset_out: got %b want 11", out_port);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
        else pass_cnt++;
        bus_read(2'd0, rd);
        total_cnt++;
        if (rd !== 32'h3) $display("FAIL reset_rd0: got %h want 00000003", rd);
        else pass_cnt++;
        bus_read(2'd1, rd);
        total_cnt++;
        if (rd !== 32'h3) $display("FAIL reset_rd1: got %h want 00000003", rd);
        else pass_cnt++;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL reset_rd3: got %h want 00000000", rd);
        else pass_cnt++;
    endtask

    task automatic test_gap();
        int n;
        logic [31:0] rd;
        bit bad_out;
        bus_write(2'd0, 32'h2);
        n = 0;
        bad_out = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (busy === 1'b1) begin
                n++;
                if (out_port !== 2'b11) bad_out = 1'b1;
            end else if (n > 0) begin
                break;
            end
        end
        total_cnt++;
        if (n != 4) $display("FAIL gap_busy_cycles: got %0d want 4", n);
        else pass_cnt++;
        total_cnt++;
        if (bad_out) $display("FAIL gap_out_held: got select low during gap want 11");
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 2'b10) $display("FAIL gap_final: got %b want 10", out_port);
        else pass_cnt++;
        bus_read(2'd0, rd);
        total_cnt++;
        if (rd !== 32'h2) $display("FAIL gap_rd0: got %h want 00000002", rd);
        else pass_cnt++;
        bus_write(2'd0, 32'h3);
        tick();
        total_cnt++;
        if (out_port !== 2'b11 || busy !== 1'b0)
            $display("FAIL deassert_nogap: got out=%b busy=%b want out=11 busy=0", out_port, busy);
        else pass_cnt++;
    endtask

    task automatic test_assert_gap();
        int n;
        bit ok;
        logic [31:0] rd;
        bus_write(2'd0, 32'h2);
        wait_out(2'b10, ok);
        total_cnt++;
        if (!ok) $display("FAIL assert_setup: got %b want 10", out_port);
        else pass_cnt++;
        bus_write(2'd1, 32'h2);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (out_port === 2'b11) n++;
            else break;
        end
        total_cnt++;
        if (n != 4) $display("FAIL assert_gap_len: got %0d want 4", n);
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 2'b00) $display("FAIL assert_final: got %b want 00", out_port);
        else pass_cnt++;

        bus_write(2'd0, 32'h3);
        wait_out(2'b11, ok);
        bus_write(2'd0, 32'h2);
        wait_out(2'b10, ok);
        bus_write(2'd1, 32'h2);
        tick();
        total_cnt++;
        if (out_port !== 2'b11 || busy !== 1'b1)
            $display("FAIL midgap_start: got out=%b busy=%b want out=11 busy=1", out_port, busy);
        else pass_cnt++;
        bus_write(2'd2, 32'h1);
        tick();
        tick();
        total_cnt++;
        if (out_port !== 2'b11 || busy !== 1'b1)
            $display("FAIL midgap_norestart_hold: got out=%b busy=%b want out=11 busy=1", out_port, busy);
        else pass_cnt++;
        tick();
        total_cnt++;
        if (out_port !== 2'b01 || busy !== 1'b0)
            $display("FAIL midgap_end: got out=%b busy=%b want out=01 busy=0", out_port, busy);
        else pass_cnt++;
        bus_read(2'd1, rd);
        total_cnt++;
        if (rd !== 32'h1) $display("FAIL midgap_target: got %h want 00000001", rd);
        else pass_cnt++;
    endtask

    task automatic test_watchdog();
        int n;
        bit ok;
        logic [31:0] rd;
        bus_write(2'd0, 32'h3);
        wait_out(2'b11, ok);
        bus_write(2'd3, 32'd10);
        bus_write(2'd0, 32'h2);
        wait_out(2'b10, ok);
        total_cnt++;
        if (!ok) $display("FAIL wdog_setup: got %b want 10", out_port);
        else pass_cnt++;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_port === 2'b10) n++;
            else break;
            tick();
        end
        total_cnt++;
        if (n != 10) $display("FAIL wdog_low_cycles: got %0d want 10", n);
        else pass_cnt++;
        total_cnt++;
        if (out_port !== 2'b11) $display("FAIL wdog_out: got %b want 11", out_port);
        else pass_cnt++;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h4000_000A) $display("FAIL wdog_ctrl_flag: got %h want 4000000a", rd);
        else pass_cnt++;
        bus_read(2'd1, rd);
        total_cnt++;
        if (rd !== 32'h3) $display("FAIL wdog_target: got %h want 00000003", rd);
        else pass_cnt++;
        bus_write(2'd3, 32'h4000_000A);
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h0000_000A) $display("FAIL wdog_flag_clear: got %h want 0000000a", rd);
        else pass_cnt++;
    endtask

    task automatic test_expiry_suppress();
        int n;
        bit ok;
        logic [31:0] rd;
        bus_write(2'd0, 32'h2);
        wait_out(2'b10, ok);
        // Now in the first low cycle; move to the tenth, where expiry would fire.
        repeat (9) tick();
        bus_write(2'd2, 32'h0);
        total_cnt++;
        if (out_port !== 2'b10) $display("FAIL suppress_out: got %b want 10", out_port);
        else pass_cnt++;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd[30] !== 1'b0) $display("FAIL suppress_flag: got %b want 0", rd[30]);
        else pass_cnt++;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            if (out_port === 2'b10) n++;
            else break;
            tick();
        end
        total_cnt++;
        if (n != 10) $display("FAIL suppress_restart: got %0d want 10", n);
        else pass_cnt++;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h4000_000A || out_port !== 2'b11)
            $display("FAIL suppress_expiry: got ctrl=%h out=%b want ctrl=4000000a out=11", rd, out_port);
        else pass_cnt++;
    endtask

    task automatic test_async_reset();
        bit ok;
        logic [31:0] rd;
        bus_write(2'd0, 32'h2);
        tick();
        tick();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL areset_gap_setup: got busy=%b want 1", busy);
        else pass_cnt++;
        #3;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_port !== 2'b11 || busy !== 1'b0)
            $display("FAIL areset_gap: got out=%b busy=%b want out=11 busy=0", out_port, busy);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL areset_ctrl: got %h want 00000000", rd);
        else pass_cnt++;

        bus_write(2'd3, 32'd100);
        bus_write(2'd0, 32'h1);
        wait_out(2'b01, ok);
        total_cnt++;
        if (!ok) $display("FAIL areset_active_setup: got %b want 01", out_port);
        else pass_cnt++;
        #3;
        reset_n = 1'b0;
        #1;
        total_cnt++;
        if (out_port !== 2'b11) $display("FAIL areset_active: got %b want 11", out_port);
        else pass_cnt++;
        @(negedge clk);
        reset_n = 1'b1;
        bus_read(2'd3, rd);
        total_cnt++;
        if (rd !== 32'h0) $display("FAIL areset_active_ctrl: got %h want 00000000", rd);
        else pass_cnt++;
        bus_read(2'd1, rd);
        total_cnt++;
        if (rd !== 32'h3) $display("FAIL areset_target: got %h want 00000003", rd);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_gap();
        test_assert_gap();
        test_watchdog();
        test_expiry_suppress();
        test_async_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no completion want finish before 200000");
        $fatal(1, "simulation time limit");
    end

endmodule
